simd_inst_sequencer: RTL

- Upstream feeder of the SIMD ALU pipeline; accepts one warp job at a time.
- Walks the program counter from 0 to i_n_inst-1 and presents each instruction slot (pc, wid, block/accumulation offsets) on an inst rdy/ack channel.
- Bounds in-flight instructions using the pipeline's inst_commit pulses.
- Signals warp completion once every issued instruction has committed.

---
 rtl/simd_inst_sequencer_pkg.sv | 23 ++
 rtl/simd_inflight_counter.sv | 51 +++++
 rtl/simd_inst_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/simd_inst_sequencer_pkg.sv
// Shared configuration for the SIMD instruction sequencer: sizes, derived widths,
// the offset vector type and the sequencer state encoding.
package simd_inst_sequencer_pkg;

    localparam int N_INST           = 16;
    localparam int MAX_WARP         = 8;
    localparam int VDIM             = 4;
    localparam int WORK_BW          = 16;
    localparam int ALU_MAX_INFLIGHT = 4;

    localparam int INST_BW = $clog2(N_INST + 1);
    localparam int WID_BW  = $clog2(MAX_WARP);
    localparam int IF_BW   = $clog2(ALU_MAX_INFLIGHT + 1);

    typedef logic [VDIM-1:0][WORK_BW-1:0] ofs_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/simd_inflight_counter.sv
// Up/down saturating count of issued-but-uncommitted instructions. Full/empty
// describe the count after this cycle's update so callers can register decisions.
module simd_inflight_counter
    import simd_inst_sequencer_pkg::*;
#(
    parameter int MAX = ALU_MAX_INFLIGHT,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty,
    output logic o_err
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case ({i_inc, i_dec})
            2'b10: if (cnt_q != CW'(MAX)) cnt_d = cnt_q + CW'(1);
            2'b01: begin
                // A retire with nothing outstanding is a protocol error; the count holds at zero.
                if (cnt_q == '0) err_d = 1'b1;
                else             cnt_d = cnt_q - CW'(1);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_full  = (cnt_d == CW'(MAX));
    assign o_empty = (cnt_d == '0);
    assign o_err   = err_q;

endmodule

// File: rtl/simd_inst_sequencer.sv
// Accepts one warp job, issues its instruction slots pc=0..n_inst-1 on a rdy/ack
// channel with a bounded in-flight window, and pulses done once all have committed.
module simd_inst_sequencer
    import simd_inst_sequencer_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            warp_rdy,
    output logic                            warp_ack,
    input  logic [WID_BW-1:0]               i_wid,
    input  logic [VDIM-1:0][WORK_BW-1:0]    i_bofs,
    input  logic [VDIM-1:0][WORK_BW-1:0]    i_aofs,
    input  logic [INST_BW-1:0]              i_n_inst,
    output logic                            inst_rdy,
    input  logic                            inst_ack,
    output logic [INST_BW-1:0]              o_pc,
    output logic [WID_BW-1:0]               o_wid,
    output logic [VDIM-1:0][WORK_BW-1:0]    o_bofs,
    output logic [VDIM-1:0][WORK_BW-1:0]    o_aofs,
    input  logic                            inst_commit_dval,
    output logic                            done_dval,
    output logic [WID_BW-1:0]               o_done_wid,
    output logic                            o_err
);

    seq_state_t          state_q, state_d;
    logic [INST_BW-1:0]  pc_q, pc_d, n_inst_q, n_inst_d;
    logic [WID_BW-1:0]   wid_q, wid_d, done_wid_q, done_wid_d;
    ofs_vec_t            bofs_q, bofs_d, aofs_q, aofs_d;
    logic                inst_rdy_q, inst_rdy_d, done_q, done_d;
    logic                inst_xfer, if_full_next, if_empty_next;

    assign warp_ack  = warp_rdy && (state_q == IDLE);
    assign inst_xfer = inst_rdy_q && inst_ack;

    simd_inflight_counter #(.MAX(ALU_MAX_INFLIGHT), .CW(IF_BW)) u_inflight (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (inst_xfer),
        .i_dec   (inst_commit_dval),
        .o_full  (if_full_next),
        .o_empty (if_empty_next),
        .o_err   (o_err)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        n_inst_d   = n_inst_q;
        wid_d      = wid_q;
        bofs_d     = bofs_q;
        aofs_d     = aofs_q;
        done_d     = 1'b0;
        done_wid_d = done_wid_q;

        unique case (state_q)
            IDLE: begin
                if (warp_ack) begin
                    wid_d    = i_wid;
                    bofs_d   = i_bofs;
                    aofs_d   = i_aofs;
                    n_inst_d = i_n_inst;
                    pc_d     = '0;
                    state_d  = (i_n_inst == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (inst_xfer) begin
                    pc_d = pc_q + INST_BW'(1);
                    if (pc_q == n_inst_q - INST_BW'(1)) begin
                        // Last slot accepted: finish immediately if its commit also landed.
                        if (if_empty_next) begin
                            state_d    = IDLE;
                            done_d     = 1'b1;
                            done_wid_d = wid_q;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (if_empty_next) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    done_wid_d = wid_q;
                end
            end
            default: state_d = IDLE;
        endcase

        inst_rdy_d = (state_d == ISSUE) && (pc_d < n_inst_d) && !if_full_next;
    end

    // NOTE: payload registers are reset too, since the outputs must read zero out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            n_inst_q   <= '0;
            wid_q      <= '0;
            bofs_q     <= '0;
            aofs_q     <= '0;
            inst_rdy_q <= 1'b0;
            done_q     <= 1'b0;
            done_wid_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            n_inst_q   <= n_inst_d;
            wid_q      <= wid_d;
            bofs_q     <= bofs_d;
            aofs_q     <= aofs_d;
            inst_rdy_q <= inst_rdy_d;
            done_q     <= done_d;
            done_wid_q <= done_wid_d;
        end
    end

    assign inst_rdy   = inst_rdy_q;
    assign o_pc       = pc_q;
    assign o_wid      = wid_q;
    assign o_bofs     = bofs_q;
    assign o_aofs     = aofs_q;
    assign done_dval  = done_q;
    assign o_done_wid = done_wid_q;

endmodule
